// File: rtl/tdm_demultiplexer_if.sv
// Serial TDM input and eight-channel parallel output bundle for tdm_demultiplexer.
// The master modport drives the serial side; the slave modport is the demultiplexer.
interface tdm_demultiplexer_if;
  logic din;
  logic din_valid;
  logic sync;
  logic d0;
  logic d1;
  logic d2;
  logic d3;
  logic d4;
  logic d5;
  logic d6;
  logic d7;
  logic frame_valid;
  logic err;
  logic busy;

  modport master (
    output din, din_valid, sync,
    input  d0, d1, d2, d3, d4, d5, d6, d7, frame_valid, err, busy
  );

  modport slave (
    input  din, din_valid, sync,
    output d0, d1, d2, d3, d4, d5, d6, d7, frame_valid, err, busy
  );
endinterface

// File: rtl/tdm_demultiplexer.sv
// Serial TDM frame demultiplexer: 8 one-bit slots, sync marks slot 0, idle timeout abort.
// Optional even-parity beat after slot 7 when TDM_DEMUX_PARITY_EN is defined.
module tdm_demultiplexer #(
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  tdm_demultiplexer_if.slave bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int SHADOW_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, PARITY = 2'd2} state_t;
`else
  // Slot 7 goes straight to the outputs, so only slots 0..6 need holding.
  localparam int SHADOW_W = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1} state_t;
`endif

  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic [2:0]            slot_reg, slot_next;
  logic [SHADOW_W-1:0]   shadow_reg, shadow_next;
  logic [7:0]            idle_reg, idle_next;
  logic [7:0]            d_reg, d_next;
  logic                  frame_valid_reg, frame_valid_next;
  logic                  err_reg, err_next;
  logic                  store_en;
  logic [2:0]            store_idx;
  logic                  sync_beat;

  assign sync_beat = bus.din_valid & bus.sync;

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_bad;
  assign parity_bad = ^{shadow_reg, bus.din};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    slot_next        = slot_reg;
    idle_next        = idle_reg;
    d_next           = d_reg;
    frame_valid_next = 1'b0;
    err_next         = 1'b0;
    store_en         = 1'b0;
    store_idx        = slot_reg;

    if (state_reg == IDLE) begin
      idle_next = '0;
      if (sync_beat) begin
        store_en   = 1'b1;
        store_idx  = 3'd0;
        slot_next  = 3'd1;
        state_next = COLLECT;
      end
    end else if (sync_beat) begin
      // A sync inside a frame aborts it and immediately starts the next one.
      err_next   = 1'b1;
      store_en   = 1'b1;
      store_idx  = 3'd0;
      slot_next  = 3'd1;
      idle_next  = '0;
      state_next = COLLECT;
    end else if (!bus.din_valid) begin
      if (idle_reg == IDLE_LAST) begin
        err_next   = 1'b1;
        idle_next  = '0;
        slot_next  = 3'd0;
        state_next = IDLE;
      end else begin
        idle_next = idle_reg + 8'd1;
      end
    end else begin
      idle_next = '0;
      case (state_reg)
        COLLECT: begin
          store_en  = 1'b1;
          slot_next = slot_reg + 3'd1;
          if (slot_reg == 3'd7) begin
`ifdef TDM_DEMUX_PARITY_EN
            state_next = PARITY;
`else
            d_next           = {bus.din, shadow_reg};
            frame_valid_next = 1'b1;
            state_next       = IDLE;
`endif
          end
        end
`ifdef TDM_DEMUX_PARITY_EN
        PARITY: begin
          slot_next  = 3'd0;
          state_next = IDLE;
          if (parity_bad) begin
            err_next = 1'b1;
          end else begin
            d_next           = shadow_reg;
            frame_valid_next = 1'b1;
          end
        end
`endif
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    shadow_next = shadow_reg;
    for (int i = 0; i < SHADOW_W; i++) begin
      if (store_en && (store_idx == 3'(i))) begin
        shadow_next[i] = bus.din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg        <= '0;
      shadow_reg      <= '0;
      idle_reg        <= '0;
      d_reg           <= '0;
      frame_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      slot_reg        <= slot_next;
      shadow_reg      <= shadow_next;
      idle_reg        <= idle_next;
      d_reg           <= d_next;
      frame_valid_reg <= frame_valid_next;
      err_reg         <= err_next;
    end
  end

  assign bus.d0          = d_reg[0];
  assign bus.d1          = d_reg[1];
  assign bus.d2          = d_reg[2];
  assign bus.d3          = d_reg[3];
  assign bus.d4          = d_reg[4];
  assign bus.d5          = d_reg[5];
  assign bus.d6          = d_reg[6];
  assign bus.d7          = d_reg[7];
  assign bus.frame_valid = frame_valid_reg;
  assign bus.err         = err_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Scoreboard bench for tdm_demultiplexer: stimulus queues expected frame/err events,
// a negedge monitor matches them by kind, cycle and output data.
`timescale 1ns/1ps
module tb_tdm_demultiplexer;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] model_d = 8'h00;
  logic [7:0] prev_d = 8'h00;

  typedef struct {
    int         kind;   // 1 = frame_valid, 2 = err
    logic [7:0] d;
    int         cyc;
  } exp_t;
  exp_t q[$];

  tdm_demultiplexer_if bus ();

  tdm_demultiplexer #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dout();
    return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every event must match the head of the queue; otherwise outputs hold.
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    if (rst) begin
      prev_d <= 8'h00;
    end else begin
      check("fv_err_exclusive", int'(bus.frame_valid & bus.err), 0);
      if (bus.frame_valid || bus.err) begin
        kind = bus.frame_valid ? 1 : 2;
        if (q.size() == 0) begin
          check("unexpected_event", kind, 0);
        end else begin
          e = q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_cycle", cyc, e.cyc);
          check("event_data", int'(dout()), int'(e.d));
        end
        $display("event kind=%0d d=%02h cycle=%0d", kind, dout(), cyc);
      end else begin
        check("d_stable", int'(dout()), int'(prev_d));
      end
      prev_d <= dout();
    end
  end

  task automatic drive(input logic v, input logic s, input logic b,
                       input int ev, input logic [7:0] nd);
    exp_t e;
    @(posedge clk);
    #1;
    bus.din_valid = v;
    bus.sync      = s;
    bus.din       = b;
    if (ev == 1) model_d = nd;
    if (ev != 0) begin
      e.kind = ev;
      e.d    = model_d;
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n, input int ev_last);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, (i == n - 1) ? ev_last : 0, 8'h00);
  endtask

  task automatic send_part(input logic [7:0] bits, input int from, input int upto,
                           input int first_ev);
    for (int i = from; i < upto; i++)
      drive(1'b1, (i == 0), bits[i], (i == from) ? first_ev : 0, 8'h00);
  endtask

  task automatic finish_frame(input logic [7:0] bits);
`ifdef TDM_DEMUX_PARITY_EN
    drive(1'b1, 1'b0, bits[7], 0, 8'h00);
    drive(1'b1, 1'b0, ^bits, 1, bits);
`else
    drive(1'b1, 1'b0, bits[7], 1, bits);
`endif
  endtask

  task automatic send_frame(input logic [7:0] bits, input int first_ev);
    send_part(bits, 0, 7, first_ev);
    finish_frame(bits);
  endtask

  initial begin
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_d", int'(dout()), 0);
    check("reset_frame_valid", int'(bus.frame_valid), 0);
    check("reset_err", int'(bus.err), 0);
    check("reset_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame: slots 1,0,1,1,0,0,1,0.
    send_frame(8'h4D, 0);
    idle(2, 0);
    @(negedge clk);
    check("busy_after_frame", int'(bus.busy), 0);

    // Back-to-back all-ones then all-zeros frames.
    send_frame(8'hFF, 0);
    send_frame(8'h00, 0);
    idle(2, 0);

    // Sync at slot 4 aborts; the sync beat starts a new frame.
    send_part(8'hAA, 0, 4, 0);
    send_frame(8'h3C, 2);
    idle(2, 0);

    // Three idle cycles inside a frame stay below the timeout.
    send_part(8'h96, 0, 3, 0);
    idle(3, 0);
    send_part(8'h96, 3, 7, 0);
    finish_frame(8'h96);
    idle(2, 0);

    // Four idle cycles after slot 3 time out; a later non-sync beat is ignored.
    send_part(8'hFF, 0, 4, 0);
    idle(1, 0);
    @(negedge clk);
    check("busy_mid_frame", int'(bus.busy), 1);
    idle(3, 2);
    drive(1'b1, 1'b0, 1'b1, 0, 8'h00);
    @(negedge clk);
    check("busy_after_timeout", int'(bus.busy), 0);
    idle(3, 0);
    @(negedge clk);
    check("busy_ignores_nonsync", int'(bus.busy), 0);

    // Reset after slot 5 discards the partial frame silently.
    send_part(8'h0F, 0, 6, 0);
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    rst           = 1'b1;
    model_d       = 8'h00;
    @(negedge clk);
    check("midrst_d", int'(dout()), 0);
    check("midrst_frame_valid", int'(bus.frame_valid), 0);
    check("midrst_err", int'(bus.err), 0);
    check("midrst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(8'h5A, 0);
    idle(3, 0);

`ifdef TDM_DEMUX_PARITY_EN
    // Good parity accepted, bad parity rejected with outputs held.
    send_frame(8'h83, 0);
    idle(2, 0);
    send_part(8'h83, 0, 7, 0);
    drive(1'b1, 1'b0, 1'b1, 0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2, 8'h00);
    idle(3, 0);
`endif

    idle(3, 0);
    @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
